// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types plus arbiter policy/state enums.
// Imported by the arbiter and by future bus splitters.
package cbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_policy_t;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner selection: fixed priority or round-robin
// starting at rr_ptr_i and wrapping modulo N.
module cbus_arb_pick
    import cbus_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    input  arb_policy_t      policy_i,
    output logic [IDX_W-1:0] win_o,
    output logic             found_o
);

    int               s;
    logic [IDX_W-1:0] j;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        s       = 0;
        j       = '0;
        for (int i = 0; i < N; i++) begin
            s = (policy_i == ARB_RR) ? i + int'(rr_ptr_i) : i;
            if (s >= N) s = s - N;
            j = IDX_W'(s);
            if (!found_o && valid_i[j]) begin
                found_o = 1'b1;
                win_o   = j;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 CBus arbiter; grant held until the last response beat.
// Define CBUS_ARB_PERF_EN to build the per-master perf counters.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int POLICY = 0,
    localparam int IDX_W = idx_w(NUM_MASTERS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  cbus_req_t         ireqs [NUM_MASTERS],
    output cbus_resp_t        oresps [NUM_MASTERS],
    output cbus_req_t         oreq,
    input  cbus_resp_t        oresp,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              busy,
    output logic [31:0]       perf_grants [NUM_MASTERS],
    output logic [31:0]       perf_wait [NUM_MASTERS]
);

    localparam arb_policy_t POL = (POLICY == 1) ? ARB_RR : ARB_FIXED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        win;
    logic                    found;
    logic                    done;
    logic [NUM_MASTERS-1:0]  valids;

    always_comb begin
        valids = '0;
        for (int i = 0; i < NUM_MASTERS; i++) valids[i] = ireqs[i].valid;
    end

    assign done = (state_q == ARB_BUSY) && oresp.ready && oresp.last;

    cbus_arb_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .valid_i  (valids),
        .rr_ptr_i (rr_q),
        .policy_i (POL),
        .win_o    (win),
        .found_o  (found)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    grant_d = win;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    if (POL == ARB_RR) begin
                        rr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    // Only the owner sees the slave; everyone else stalls on ready = 0.
    always_comb begin
        oreq = '0;
        busy = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) oresps[i] = '0;
        if (state_q == ARB_BUSY) begin
            oreq            = ireqs[grant_q];
            oresps[grant_q] = oresp;
            busy            = 1'b1;
        end
    end

    assign grant_idx = grant_q;

`ifdef CBUS_ARB_PERF_EN
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_perf
        logic        own;
        logic [31:0] grants_q;
        logic [31:0] wait_q;

        assign own = (state_q == ARB_BUSY) && (grant_q == IDX_W'(i));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                grants_q <= '0;
                wait_q   <= '0;
            end else begin
                if (own && done) grants_q <= grants_q + 32'd1;
                if (ireqs[i].valid && !own) wait_q <= wait_q + 32'd1;
            end
        end

        assign perf_grants[i] = grants_q;
        assign perf_wait[i]   = wait_q;
    end
`else
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_noperf
        assign perf_grants[i] = '0;
        assign perf_wait[i]   = '0;
    end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench: 2-master fixed-priority and 3-master round-robin
// arbiters, vector table plus hand sequences for reset and perf.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

`ifdef CBUS_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h1fc0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;

    cbus_req_t   r2 [2];
    cbus_resp_t  s2 [2];
    cbus_req_t   q2;
    cbus_resp_t  p2;
    logic        g2;
    logic        b2;
    logic [31:0] pg2 [2];
    logic [31:0] pw2 [2];

    cbus_req_t   r3 [3];
    cbus_resp_t  s3 [3];
    cbus_req_t   q3;
    cbus_resp_t  p3;
    logic [1:0]  g3;
    logic        b3;
    logic [31:0] pg3 [3];
    logic [31:0] pw3 [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_MASTERS(2), .POLICY(0)) u_fix (
        .clk(clk), .resetn(resetn), .ireqs(r2), .oresps(s2),
        .oreq(q2), .oresp(p2), .grant_idx(g2), .busy(b2),
        .perf_grants(pg2), .perf_wait(pw2)
    );

    cbus_arbiter #(.NUM_MASTERS(3), .POLICY(1)) u_rr (
        .clk(clk), .resetn(resetn), .ireqs(r3), .oresps(s3),
        .oreq(q3), .oresp(p3), .grant_idx(g3), .busy(b3),
        .perf_grants(pg3), .perf_wait(pw3)
    );

    typedef struct {
        logic [1:0]  v;
        logic        rdy;
        logic        lst;
        logic [31:0] d;
        logic        eb;
        logic        eg;
        logic        eov;
        logic [31:0] ea;
        logic [1:0]  er;
        logic [1:0]  el;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t t [30];

    function automatic vec_t V(
        input logic [1:0] v, input logic rdy, input logic lst,
        input logic [31:0] d, input logic eb, input logic eg,
        input logic eov, input logic [31:0] ea, input logic [1:0] er,
        input logic [1:0] el, input logic [31:0] e0, input logic [31:0] e1
    );
        vec_t x;
        x.v = v; x.rdy = rdy; x.lst = lst; x.d = d;
        x.eb = eb; x.eg = eg; x.eov = eov; x.ea = ea;
        x.er = er; x.el = el; x.e0 = e0; x.e1 = e1;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive2(input logic [1:0] v, input logic rdy,
                          input logic lst, input logic [31:0] d);
        @(negedge clk);
        r2[0].valid = v[0];
        r2[1].valid = v[1];
        p2.ready = rdy;
        p2.last  = lst;
        p2.data  = d;
        #1;
    endtask

    function automatic logic [127:0] obs2();
        return {25'd0, b2, g2, q2.valid, q2.addr,
                s2[1].ready, s2[0].ready, s2[1].last, s2[0].last,
                s2[0].data, s2[1].data};
    endfunction

    initial begin #200000; $display("FAIL watchdog: time limit hit"); $fatal(1); end

    initial begin
        int seq [9];
        logic [31:0] e32;
        seq = '{0, 1, 2, 0, 1, 2, 0, 2, 0};

        r2[0] = '0; r2[0].addr = A0; r2[0].len = 8'd3;
        r2[1] = '0; r2[1].addr = A1;
        p2 = '0;
        for (int i = 0; i < 3; i++) begin
            r3[i] = '0;
            r3[i].addr = 32'h3000 + 32'(i) * 32'h100;
        end
        p3 = '0; p3.ready = 1'b1; p3.last = 1'b1;

        // asynchronous reset, before any clock edge
        #2 resetn = 1'b0;
        #1;
        chk("reset_fix", {obs2(), 1'b0} | {pg2[0], pw2[0], pg2[1], pw2[1]}, '0);
        chk("reset_rr", {b3, g3, q3}, '0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive2(2'b00, 1'b0, 1'b0, 32'd0);
            chk("idle", {b2, g2, q2.valid}, 3'b000);
        end

        t[0]  = V(2'b00, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[1]  = V(2'b10, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[2]  = V(2'b10, 0, 0, 0,   1, 1, 1, A1, 2'b00, 2'b00, 0, 0);
        t[3]  = V(2'b10, 0, 0, 0,   1, 1, 1, A1, 2'b00, 2'b00, 0, 0);
        t[4]  = V(2'b10, 1, 1, 32'hdeadbeef,
                  1, 1, 1, A1, 2'b10, 2'b10, 0, 32'hdeadbeef);
        t[5]  = V(2'b00, 1, 1, 32'hff, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        t[6]  = V(2'b11, 0, 0, 0,   0, 1, 0, 0,  2'b00, 2'b00, 0, 0);
        t[7]  = V(2'b11, 1, 1, 32'h11, 1, 0, 1, A0, 2'b01, 2'b01, 32'h11, 0);
        t[8]  = V(2'b11, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[9]  = V(2'b11, 1, 1, 32'h22, 1, 0, 1, A0, 2'b01, 2'b01, 32'h22, 0);
        t[10] = V(2'b11, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[11] = V(2'b11, 1, 1, 32'h33, 1, 0, 1, A0, 2'b01, 2'b01, 32'h33, 0);
        t[12] = V(2'b11, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[13] = V(2'b11, 1, 1, 32'h44, 1, 0, 1, A0, 2'b01, 2'b01, 32'h44, 0);
        t[14] = V(2'b10, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[15] = V(2'b10, 1, 1, 32'h55, 1, 1, 1, A1, 2'b10, 2'b10, 0, 32'h55);
        t[16] = V(2'b00, 0, 0, 0,   0, 1, 0, 0,  2'b00, 2'b00, 0, 0);
        t[17] = V(2'b01, 0, 0, 0,   0, 1, 0, 0,  2'b00, 2'b00, 0, 0);
        t[18] = V(2'b00, 0, 0, 0,   1, 0, 0, A0, 2'b00, 2'b00, 0, 0);
        t[19] = V(2'b00, 1, 1, 32'h66, 1, 0, 0, A0, 2'b01, 2'b01, 32'h66, 0);
        t[20] = V(2'b00, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[21] = V(2'b01, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[22] = V(2'b01, 1, 0, 32'ha0, 1, 0, 1, A0, 2'b01, 2'b00, 32'ha0, 0);
        t[23] = V(2'b11, 1, 0, 32'ha1, 1, 0, 1, A0, 2'b01, 2'b00, 32'ha1, 0);
        t[24] = V(2'b11, 1, 0, 32'ha2, 1, 0, 1, A0, 2'b01, 2'b00, 32'ha2, 0);
        t[25] = V(2'b11, 1, 1, 32'ha3, 1, 0, 1, A0, 2'b01, 2'b01, 32'ha3, 0);
        t[26] = V(2'b10, 0, 0, 0,   0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        t[27] = V(2'b10, 0, 0, 0,   1, 1, 1, A1, 2'b00, 2'b00, 0, 0);
        t[28] = V(2'b10, 1, 1, 32'h77, 1, 1, 1, A1, 2'b10, 2'b10, 0, 32'h77);
        t[29] = V(2'b00, 0, 0, 0,   0, 1, 0, 0,  2'b00, 2'b00, 0, 0);

        for (int k = 0; k < 30; k++) begin
            drive2(t[k].v, t[k].rdy, t[k].lst, t[k].d);
            chk($sformatf("vec%0d", k), obs2(),
                {25'd0, t[k].eb, t[k].eg, t[k].eov, t[k].ea,
                 t[k].er, t[k].el, t[k].e0, t[k].e1});
        end
        drive2(2'b00, 1'b0, 1'b0, 32'd0);

        // round-robin: all valid, single-beat; master 1 drops at c=12
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) r3[i].valid = !(c >= 12 && i == 1);
            #1;
            if (c % 2 == 1) begin
                e32 = 32'h3000 + 32'(seq[c / 2]) * 32'h100;
                chk($sformatf("rr_busy%0d", c),
                    {b3, g3, q3.valid, q3.addr,
                     s3[0].ready | s3[1].ready | s3[2].ready},
                    {1'b1, 2'(seq[c / 2]), 1'b1, e32, 1'b1});
            end else begin
                chk($sformatf("rr_idle%0d", c), {b3, g3, q3.valid},
                    {1'b0, (c == 0) ? 2'd0 : 2'(seq[c / 2 - 1]), 1'b0});
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) r3[i].valid = 1'b0;

        // reset in the middle of a 4-beat burst
        drive2(2'b01, 1'b0, 1'b0, 32'd0);
        drive2(2'b01, 1'b1, 1'b0, 32'hb0);
        drive2(2'b01, 1'b1, 1'b0, 32'hb1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_out", {b2, g2, q2, s2[0], s2[1]}, '0);
        chk("rst_mid_perf", {pg2[0], pw2[0], pg2[1], pw2[1]}, '0);
        @(negedge clk);
        r2[0].valid = 1'b0;
        p2 = '0;
        resetn = 1'b1;

        // master 1 waits: arbitration + 5 busy beats + 1 idle = 7
        drive2(2'b11, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) drive2(2'b11, 1'b1, 1'b0, 32'hc0);
        drive2(2'b11, 1'b1, 1'b1, 32'hc1);
        drive2(2'b10, 1'b0, 1'b0, 32'd0);
        drive2(2'b10, 1'b0, 1'b0, 32'd0);
        chk("perf_own1", {b2, g2}, 2'b11);
        chk("perf_wait1", pw2[1], PERF ? 32'd7 : 32'd0);
        chk("perf_wait0", pw2[0], PERF ? 32'd1 : 32'd0);
        chk("perf_grant0", {pg2[0], pg2[1]}, PERF ? {32'd1, 32'd0} : 64'd0);
        drive2(2'b10, 1'b1, 1'b1, 32'hd0);
        drive2(2'b00, 1'b0, 1'b0, 32'd0);
        chk("perf_grant1", {pg2[1], pw2[1]}, PERF ? {32'd1, 32'd7} : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
